// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Hazard and stall controller for the five-stage core. Combines three stall
// sources into the per-stage stall vector and jump flush that every pipeline
// register obeys:
//   - MEM-stage bus wait (with timeout abort),
//   - multi-cycle divide (fixed latency timer),
//   - load-use hazard between the load in EXE and the consumer in ID.
// A saturating counter records how many cycles the front of the pipe (pc) is
// held.
//
// Parameters
//   DIV_LATENCY    cycles the pipeline is held per divide (2..63)
//   MEM_TIMEOUT    max MEM wait cycles before the access is aborted (2..255)
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              asynchronous reset, active low
//   id_rs1_raddr_i     ID source register 1 address
//   id_rs2_raddr_i     ID source register 2 address
//   id_rs1_re_i        ID source register 1 read enable
//   id_rs2_re_i        ID source register 2 read enable
//   ex_inst_is_load_i  instruction in EXE is a load
//   ex_rd_i            EXE destination register
//   ex_jump_i          EXE resolves a taken jump/branch
//   ex_div_start_i     EXE holds a div/rem instruction
//   mem_req_i          MEM stage has a bus access pending (level)
//   mem_ack_i          bus completion valid this cycle
//   stall_o            stall vector, bit i holds stage i
//                      (0 pc, 1 if_id, 2 id_exe, 3 exe_mem, 4 mem_wb, 5 wb)
//   flush_jump_o       flush if_id and id_exe
//   div_done_o         one-cycle pulse: divide result valid
//   bus_err_o          one-cycle pulse: MEM wait timed out
//   stall_cycles_o     saturating count of cycles with stall_o[0] set
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int DIV_LATENCY = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_raddr_i,
  input  logic [4:0]  id_rs2_raddr_i,
  input  logic        id_rs1_re_i,
  input  logic        id_rs2_re_i,
  input  logic        ex_inst_is_load_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_jump_i,
  input  logic        ex_div_start_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic [5:0]  stall_o,
  output logic        flush_jump_o,
  output logic        div_done_o,
  output logic        bus_err_o,
  output logic [31:0] stall_cycles_o
);

  // Divide start loads the remaining-stall count; the start cycle itself is
  // the first stall cycle, hence the minus one.
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_LATENCY - 1);
  // Last wait cycle index before the MEM access is declared dead.
  localparam logic [7:0] MEM_LAST  = 8'(MEM_TIMEOUT - 1);

  // Stall patterns: each holds every stage upstream of the blocking one.
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_DIV  = 6'b001111;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [0:0] {
    D_IDLE = 1'b0,
    D_BUSY = 1'b1
  } div_state_t;

  mem_state_t  mem_state_r;
  mem_state_t  mem_state_nxt_s;
  logic [7:0]  mcnt_r;
  logic [7:0]  mcnt_nxt_s;
  logic        mem_stall_s;
  logic        mem_timeout_s;

  div_state_t  div_state_r;
  div_state_t  div_state_nxt_s;
  logic [5:0]  dcnt_r;
  logic [5:0]  dcnt_nxt_s;
  logic        div_stall_s;
  logic        div_done_s;

  logic        rs1_hit_s;
  logic        rs2_hit_s;
  logic        load_use_s;

  logic [5:0]  stall_s;
  logic        flush_s;
  logic        done_s;
  logic        err_s;

  logic [31:0] stall_cycles_r;

  // MEM FSM state and wait counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_state_r <= M_IDLE;
      mcnt_r      <= 8'd0;
    end else begin
      mem_state_r <= mem_state_nxt_s;
      mcnt_r      <= mcnt_nxt_s;
    end
  end

  // MEM FSM next state: stall while the bus owes us an ack, abort on timeout
  always_comb begin
    mem_state_nxt_s = mem_state_r;
    mcnt_nxt_s      = mcnt_r;
    mem_stall_s     = 1'b0;
    mem_timeout_s   = 1'b0;
    case (mem_state_r)
      M_IDLE: begin
        // An ack in the request cycle completes with no stall at all.
        if (mem_req_i && !mem_ack_i) begin
          mem_stall_s     = 1'b1;
          mcnt_nxt_s      = 8'd0;
          mem_state_nxt_s = M_WAIT;
        end else begin
          mem_state_nxt_s = M_IDLE;
        end
      end
      M_WAIT: begin
        if (mem_ack_i) begin
          mem_state_nxt_s = M_IDLE;
        end else if (mcnt_r == MEM_LAST) begin
          // Release the pipe and report; the access is abandoned.
          mem_timeout_s   = 1'b1;
          mem_state_nxt_s = M_IDLE;
        end else begin
          mem_stall_s     = 1'b1;
          mcnt_nxt_s      = mcnt_r + 8'd1;
          mem_state_nxt_s = M_WAIT;
        end
      end
      default: begin
        mem_state_nxt_s = M_IDLE;
        mcnt_nxt_s      = 8'd0;
      end
    endcase
  end

  // DIV FSM state and latency counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_state_r <= D_IDLE;
      dcnt_r      <= 6'd0;
    end else begin
      div_state_r <= div_state_nxt_s;
      dcnt_r      <= dcnt_nxt_s;
    end
  end

  // DIV FSM next state: fixed-latency timer, completion deferred by mem stall
  always_comb begin
    div_state_nxt_s = div_state_r;
    dcnt_nxt_s      = dcnt_r;
    div_stall_s     = 1'b0;
    div_done_s      = 1'b0;
    case (div_state_r)
      D_IDLE: begin
        if (ex_div_start_i) begin
          div_stall_s     = 1'b1;
          dcnt_nxt_s      = DIV_LOAD;
          div_state_nxt_s = D_BUSY;
        end else begin
          div_state_nxt_s = D_IDLE;
        end
      end
      D_BUSY: begin
        // The divider keeps computing while MEM holds the pipe, so the
        // count runs down regardless; only the hand-off waits.
        if (dcnt_r != 6'd0) begin
          div_stall_s     = 1'b1;
          dcnt_nxt_s      = dcnt_r - 6'd1;
          div_state_nxt_s = D_BUSY;
        end else if (mem_stall_s) begin
          // EXE cannot advance under a MEM stall; keep the result pending.
          div_stall_s     = 1'b1;
          div_state_nxt_s = D_BUSY;
        end else begin
          div_done_s      = 1'b1;
          div_state_nxt_s = D_IDLE;
        end
      end
      default: begin
        div_state_nxt_s = D_IDLE;
        dcnt_nxt_s      = 6'd0;
      end
    endcase
  end

  // Load-use hazard detection between the EXE load and the ID consumer
  always_comb begin
    rs1_hit_s  = 1'b0;
    rs2_hit_s  = 1'b0;
    load_use_s = 1'b0;
    if (ex_inst_is_load_i && (ex_rd_i != 5'd0)) begin
      rs1_hit_s  = id_rs1_re_i && (id_rs1_raddr_i == ex_rd_i);
      rs2_hit_s  = id_rs2_re_i && (id_rs2_raddr_i == ex_rd_i);
      load_use_s = rs1_hit_s || rs2_hit_s;
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Priority arbitration of stall sources; reset forces every output quiet
  always_comb begin
    stall_s = STALL_NONE;
    flush_s = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    if (!rst_i) begin
      stall_s = STALL_NONE;
      flush_s = 1'b0;
      done_s  = 1'b0;
      err_s   = 1'b0;
    end else begin
      done_s = div_done_s;
      err_s  = mem_timeout_s;
      if (mem_stall_s) begin
        stall_s = STALL_MEM;
      end else if (div_stall_s) begin
        stall_s = STALL_DIV;
      end else if (ex_jump_i) begin
        // The ID instruction is on the wrong path, so its hazard is moot.
        stall_s = STALL_NONE;
        flush_s = 1'b1;
      end else if (load_use_s) begin
        stall_s = STALL_LU;
      end else begin
        stall_s = STALL_NONE;
      end
    end
  end

  // Saturating count of cycles in which the pc is held
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cycles_r <= 32'd0;
    end else if (stall_s[0] && (stall_cycles_r != CNT_MAX)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end
  end

  assign stall_o        = stall_s;
  assign flush_jump_o   = flush_s;
  assign div_done_o     = done_s;
  assign bus_err_o      = err_s;
  assign stall_cycles_o = stall_cycles_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int DL = 4;
  localparam int MT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        re1, re2, ld, jmp, dstart, req, ack;
  logic [5:0]  stall;
  logic        flush, done, err;
  logic [31:0] sc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DIV_LATENCY(DL), .MEM_TIMEOUT(MT)) dut (
    .clk_i             (clk),
    .rst_i             (rst_n),
    .id_rs1_raddr_i    (rs1),
    .id_rs2_raddr_i    (rs2),
    .id_rs1_re_i       (re1),
    .id_rs2_re_i       (re2),
    .ex_inst_is_load_i (ld),
    .ex_rd_i           (rd),
    .ex_jump_i         (jmp),
    .ex_div_start_i    (dstart),
    .mem_req_i         (req),
    .mem_ack_i         (ack),
    .stall_o           (stall),
    .flush_jump_o      (flush),
    .div_done_o        (done),
    .bus_err_o         (err),
    .stall_cycles_o    (sc)
  );

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       re1;
    logic       re2;
    logic       ld;
    logic [4:0] rd;
    logic       jmp;
    logic [5:0] exp_stall;
    logic       exp_flush;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    re1 = 1'b0; re2 = 1'b0; ld = 1'b0; jmp = 1'b0;
    dstart = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  // Inputs are set by the caller at posedge+1; sample at negedge, step on.
  task automatic expect_out(input string nm, input logic [5:0] s, input logic f,
                            input logic d, input logic e);
    @(negedge clk);
    chk({nm, ".stall"}, 32'(stall), 32'(s));
    chk({nm, ".flush"}, 32'(flush), 32'(f));
    chk({nm, ".done"},  32'(done),  32'(d));
    chk({nm, ".err"},   32'(err),   32'(e));
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    clear_in();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst.cycles", sc, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Reference model state: cycle-level bookkeeping of the stall rules.
  bit     m_wait;
  int     m_stalled;
  bit     d_busy;
  int     d_left;
  longint m_sc;

  initial begin
    logic [5:0] es;
    logic ms, ds, ef, ed, ee, lu;

    vecs[0] = '{5'd0,  5'd5,  1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 6'b000111, 1'b0};
    vecs[1] = '{5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 6'b000000, 1'b0};
    vecs[2] = '{5'd7,  5'd1,  1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 6'b000111, 1'b0};
    vecs[3] = '{5'd7,  5'd1,  1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 6'b000000, 1'b0};
    vecs[4] = '{5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 5'd7,  1'b0, 6'b000000, 1'b0};
    vecs[5] = '{5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 5'd9,  1'b1, 6'b000000, 1'b1};
    vecs[6] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 6'b000000, 1'b1};
    vecs[7] = '{5'd3,  5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 6'b000111, 1'b0};
    vecs[8] = '{5'd13, 5'd11, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 6'b000000, 1'b0};
    vecs[9] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 6'b000000, 1'b0};

    // Reset with every stall source active: outputs must stay quiet.
    clear_in();
    rst_n = 1'b0;
    jmp = 1'b1; req = 1'b1; dstart = 1'b1;
    ld = 1'b1; rd = 5'd4; rs1 = 5'd4; re1 = 1'b1;
    expect_out("reset", 6'b000000, 1'b0, 1'b0, 1'b0);
    chk("reset.cycles", sc, 32'd0);
    clear_in();
    rst_n = 1'b1;

    // Combinational load-use / jump table, FSMs idle.
    for (int i = 0; i < 10; i++) begin
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; re1 = vecs[i].re1; re2 = vecs[i].re2;
      ld = vecs[i].ld; rd = vecs[i].rd; jmp = vecs[i].jmp;
      expect_out($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush, 1'b0, 1'b0);
    end

    // Divide: 4 stall cycles, done at T+4; start held meanwhile is ignored.
    reset_pulse();
    dstart = 1'b1;
    for (int i = 0; i < DL; i++) expect_out($sformatf("div_t%0d", i), 6'b001111, 1'b0, 1'b0, 1'b0);
    expect_out("div_done", 6'b000000, 1'b0, 1'b1, 1'b0);
    dstart = 1'b0;
    chk("div.cycles", sc, 32'd4);
    expect_out("div_after", 6'b000000, 1'b0, 1'b0, 1'b0);

    // Mem wait: ack at T+3, then ack in request cycle.
    reset_pulse();
    req = 1'b1;
    for (int i = 0; i < 3; i++) expect_out($sformatf("mem_t%0d", i), 6'b011111, 1'b0, 1'b0, 1'b0);
    ack = 1'b1;
    expect_out("mem_ack", 6'b000000, 1'b0, 1'b0, 1'b0);
    req = 1'b1; ack = 1'b1;
    expect_out("mem_same", 6'b000000, 1'b0, 1'b0, 1'b0);
    req = 1'b0; ack = 1'b0;
    expect_out("mem_idle", 6'b000000, 1'b0, 1'b0, 1'b0);
    chk("mem.cycles", sc, 32'd3);

    // Timeout: 8 stall cycles then a single bus_err pulse.
    reset_pulse();
    req = 1'b1;
    for (int i = 0; i < MT; i++) expect_out($sformatf("to_t%0d", i), 6'b011111, 1'b0, 1'b0, 1'b0);
    expect_out("to_err", 6'b000000, 1'b0, 1'b0, 1'b1);
    req = 1'b0;
    expect_out("to_after", 6'b000000, 1'b0, 1'b0, 1'b0);
    chk("to.cycles", sc, 32'd8);

    // Overlap: divide at T, mem stall T+2..T+6, jump held from T+1.
    reset_pulse();
    dstart = 1'b1;
    expect_out("ov_t0", 6'b001111, 1'b0, 1'b0, 1'b0);
    dstart = 1'b0; jmp = 1'b1;
    expect_out("ov_t1", 6'b001111, 1'b0, 1'b0, 1'b0);
    req = 1'b1;
    for (int i = 2; i < 7; i++) expect_out($sformatf("ov_t%0d", i), 6'b011111, 1'b0, 1'b0, 1'b0);
    ack = 1'b1;
    expect_out("ov_t7", 6'b000000, 1'b1, 1'b1, 1'b0);
    clear_in();
    chk("ov.cycles", sc, 32'd7);
    expect_out("ov_t8", 6'b000000, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a divide: quiet at once, no done afterwards.
    reset_pulse();
    dstart = 1'b1;
    expect_out("rd_t0", 6'b001111, 1'b0, 1'b0, 1'b0);
    dstart = 1'b0;
    expect_out("rd_t1", 6'b001111, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; jmp = 1'b1; req = 1'b1;
    expect_out("rd_rst", 6'b000000, 1'b0, 1'b0, 1'b0);
    chk("rd.cycles", sc, 32'd0);
    clear_in();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) expect_out($sformatf("rd_post%0d", i), 6'b000000, 1'b0, 1'b0, 1'b0);

    // Randomized run against the reference model.
    reset_pulse();
    m_wait = 1'b0; m_stalled = 0; d_busy = 1'b0; d_left = 0; m_sc = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      rs1    = 5'($urandom_range(0, 3));
      rs2    = 5'($urandom_range(0, 3));
      rd     = 5'($urandom_range(0, 3));
      re1    = 1'($urandom_range(0, 1));
      re2    = 1'($urandom_range(0, 1));
      ld     = 1'($urandom_range(0, 1));
      jmp    = ($urandom_range(0, 5) == 0);
      dstart = ($urandom_range(0, 7) == 0);
      req    = ($urandom_range(0, 3) == 0) || m_wait;
      ack    = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      es = 6'b000000; ef = 1'b0; ed = 1'b0; ee = 1'b0;
      if (!rst_n) begin
        m_wait = 1'b0; d_busy = 1'b0; m_sc = 0;
      end else begin
        ms = 1'b0; ds = 1'b0;
        if (!m_wait) begin
          if (req && !ack) begin ms = 1'b1; m_wait = 1'b1; m_stalled = 1; end
        end else if (ack) begin
          m_wait = 1'b0;
        end else if (m_stalled == MT) begin
          ee = 1'b1; m_wait = 1'b0;
        end else begin
          ms = 1'b1; m_stalled++;
        end
        if (!d_busy) begin
          if (dstart) begin ds = 1'b1; d_busy = 1'b1; d_left = DL - 1; end
        end else if (d_left > 0) begin
          ds = 1'b1; d_left--;
        end else if (ms) begin
          ds = 1'b1;
        end else begin
          ed = 1'b1; d_busy = 1'b0;
        end
        lu = ld && (rd != 5'd0) && ((re1 && rs1 == rd) || (re2 && rs2 == rd));
        if (ms)        es = 6'b011111;
        else if (ds)   es = 6'b001111;
        else if (jmp)  ef = 1'b1;
        else if (lu)   es = 6'b000111;
      end
      chk("rnd.cycles", sc, 32'(m_sc));
      chk("rnd.stall", 32'(stall), 32'(es));
      chk("rnd.flush", 32'(flush), 32'(ef));
      chk("rnd.done",  32'(done),  32'(ed));
      chk("rnd.err",   32'(err),   32'(ee));
      if (rst_n && es[0]) m_sc++;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
